// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for fetch_sequencer: state encoding and strobe levels.
package fetch_sequencer_pkg;

  localparam int unsigned FS_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_INC  = 3'd3,
    S_HOLD = 3'd4,
    S_JUMP = 3'd5
  } fs_state_e;

  // Bus strobes are active-low, the PC increment is active-high.
  localparam logic STROBE_ON_N  = 1'b0;
  localparam logic STROBE_OFF_N = 1'b1;
  localparam logic INC_ON       = 1'b1;
  localparam logic INC_OFF      = 1'b0;

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: bus-side fetch controller. Gates the PC onto the address
// bus, strobes memory, captures the returned word into instr, pulses pc_inc
// and offers the word to decode via instr_valid/instr_ready. Jump requests
// drive jump_addr onto data_bus with pc_notWrite low.
// Optional feature: FETCH_SEQUENCER_WAIT_EN adds mem_ready and stretches DATA
// until memory signals valid data.
// Ports:
//   clk, clr          clock, synchronous active-high reset
//   data_bus          shared bus, driven only in JUMP
//   pc_notWrite       PC load-from-bus strobe (active low)
//   pc_notRead        PC output enable (active low)
//   pc_inc            PC increment pulse (active high)
//   mem_notRead       memory read strobe (active low)
//   mem_ready         memory data valid (FETCH_SEQUENCER_WAIT_EN only)
//   instr/instr_valid/instr_ready  instruction handshake to decode
//   jump_req/jump_addr/jump_ack    PC load request, target and acknowledge
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  inout  logic [DATA_WIDTH-1:0] data_bus,
  output logic                  pc_notWrite,
  output logic                  pc_notRead,
  output logic                  pc_inc,
  output logic                  mem_notRead,
`ifdef FETCH_SEQUENCER_WAIT_EN
  input  logic                  mem_ready,
`endif
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jump_req,
  input  logic [DATA_WIDTH-1:0] jump_addr,
  output logic                  jump_ack
);

  fs_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  data_go;

`ifdef FETCH_SEQUENCER_WAIT_EN
  assign data_go = mem_ready;
`else
  assign data_go = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      S_IDLE: state_d = jump_req ? S_JUMP : S_ADDR;
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        if (data_go) begin
          instr_d = data_bus;
          state_d = S_INC;
        end
      end
      S_INC: begin
        state_d       = S_HOLD;
        instr_valid_d = 1'b1;
      end
      S_HOLD: begin
        // A pending jump flushes the held word even if decode accepts it now.
        if (jump_req) begin
          state_d       = S_JUMP;
          instr_valid_d = 1'b0;
        end else if (instr_ready) begin
          state_d       = S_ADDR;
          instr_valid_d = 1'b0;
        end
      end
      S_JUMP:  state_d = S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_notWrite = STROBE_OFF_N;
    pc_notRead  = STROBE_OFF_N;
    mem_notRead = STROBE_OFF_N;
    pc_inc      = INC_OFF;
    jump_ack    = 1'b0;
    case (state_q)
      S_ADDR, S_DATA: begin
        pc_notRead  = STROBE_ON_N;
        mem_notRead = STROBE_ON_N;
      end
      S_INC:  pc_inc = INC_ON;
      S_JUMP: begin
        pc_notWrite = STROBE_ON_N;
        jump_ack    = 1'b1;
      end
      default: ;
    endcase
  end

  assign data_bus    = (state_q == S_JUMP) ? jump_addr : 'z;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule
